// File: rtl/spi_master_tx.sv
// spi_master_tx
//   SPI master for a single 15-bit slave shift stage. It frames each transfer
//   with a leading LOAD pulse, which makes the slave preload its TX word. It
//   then sends 15 bits MSB first on MOSI with SCLK. After a low gap it raises a
//   trailing LOAD pulse, which makes the slave latch the word it received. The
//   bits captured from MISO are returned on rx_data when done pulses.
//   SCLK, MOSI and LOAD are registered outputs derived from clk.
//
// Parameters
//   DIV      SCLK half-period, LOAD pulse width and phase gap in clk cycles
//            (2..255)
// Ports
//   clk      system clock, rising edge
//   clr      synchronous active-high reset
//   start    frame request, sampled only while idle
//   tx_data  word to send, captured on the accepting edge
//   rx_data  last word received, updated at frame end
//   busy     frame in progress (cycle after accept through last LOAD cycle)
//   done     one-cycle frame-complete pulse
//   SCLK     serial clock to slave, idle low
//   MOSI     serial data to slave, MSB first
//   LOAD     slave framing strobe, active high
//   MISO     serial data from slave
module spi_master_tx #(
  parameter int unsigned DIV = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [14:0] tx_data,
  output logic [14:0] rx_data,
  output logic        busy,
  output logic        done,
  output logic        SCLK,
  output logic        MOSI,
  output logic        LOAD,
  input  logic        MISO
);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    LOW,
    HIGH,
    TAIL,
    COMMIT
  } state_t;

  localparam logic [7:0] PHASE_INIT = 8'(DIV - 1);

  state_t      state, state_next;
  logic [14:0] tx_sh, tx_sh_next;
  logic [14:0] rx_sh, rx_sh_next;
  logic [14:0] rx_data_next;
  logic [3:0]  bit_cnt, bit_cnt_next;
  logic [7:0]  phase, phase_next;
  logic        sclk_next, mosi_next, load_next, busy_next, done_next;
  logic        phase_end;

  assign phase_end = (phase == '0);

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      bit_cnt <= '0;
      phase   <= PHASE_INIT;
      SCLK    <= 1'b0;
      MOSI    <= 1'b0;
      LOAD    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      tx_sh   <= tx_sh_next;
      rx_sh   <= rx_sh_next;
      rx_data <= rx_data_next;
      bit_cnt <= bit_cnt_next;
      phase   <= phase_next;
      SCLK    <= sclk_next;
      MOSI    <= mosi_next;
      LOAD    <= load_next;
      busy    <= busy_next;
      done    <= done_next;
    end
  end

  // All outputs are computed one cycle ahead, so each phase transition
  // changes the pins on the same edge that ends the phase.
  always_comb begin
    state_next   = state;
    tx_sh_next   = tx_sh;
    rx_sh_next   = rx_sh;
    rx_data_next = rx_data;
    bit_cnt_next = bit_cnt;
    phase_next   = phase_end ? PHASE_INIT : phase - 8'd1;
    sclk_next    = SCLK;
    mosi_next    = MOSI;
    load_next    = LOAD;
    busy_next    = busy;
    done_next    = 1'b0;

    case (state)
      IDLE: begin
        phase_next = PHASE_INIT;
        if (start) begin
          tx_sh_next   = tx_data;
          bit_cnt_next = 4'd14;
          load_next    = 1'b1;
          busy_next    = 1'b1;
          state_next   = LEAD;
        end
      end
      LEAD: begin
        if (phase_end) begin
          load_next  = 1'b0;
          mosi_next  = tx_sh[14];
          state_next = LOW;
        end
      end
      LOW: begin
        if (phase_end) begin
          sclk_next  = 1'b1;
          state_next = HIGH;
        end
      end
      HIGH: begin
        // MISO is stable for the whole high phase because the slave shifts
        // only on the falling edge, so sampling it at the end is safe.
        if (phase_end) begin
          rx_sh_next = {rx_sh[13:0], MISO};
          sclk_next  = 1'b0;
          if (bit_cnt == 4'd0) begin
            state_next = TAIL;
          end else begin
            bit_cnt_next = bit_cnt - 4'd1;
            tx_sh_next   = {tx_sh[13:0], 1'b0};
            mosi_next    = tx_sh[13];
            state_next   = LOW;
          end
        end
      end
      TAIL: begin
        if (phase_end) begin
          load_next  = 1'b1;
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        if (phase_end) begin
          load_next    = 1'b0;
          mosi_next    = 1'b0;
          rx_data_next = rx_sh;
          done_next    = 1'b1;
          busy_next    = 1'b0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// tb_spi_master_tx
//   Bench for spi_master_tx. Instance 0 runs with DIV=4 and instance 1 with
//   DIV=2. Each instance is wired to a behavioural slave shift stage.
//   Expected values come from the frame timing rules and from the data each
//   frame should carry.
module tb_spi_master_tx;

  localparam int DIV0 = 4;
  localparam int DIV1 = 2;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [1:0]  start_r = '0;
  logic [29:0] txd_r = '0;

  wire  [29:0] rxd_w;
  wire  [1:0]  busy_w, done_w, sclk_w, mosi_w, load_w, miso_w;

  // Slave model state, two 15-bit slices packed side by side.
  logic [29:0] s_di = '0;
  logic [29:0] s_do = '0;
  logic [29:0] s_tx = '0;
  logic [29:0] s_rx = '0;
  logic [1:0]  ps_sclk = '0;
  logic [1:0]  ps_load = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spi_master_tx #(.DIV(DIV0)) dut0 (
    .clk(clk), .clr(clr), .start(start_r[0]), .tx_data(txd_r[14:0]),
    .rx_data(rxd_w[14:0]), .busy(busy_w[0]), .done(done_w[0]),
    .SCLK(sclk_w[0]), .MOSI(mosi_w[0]), .LOAD(load_w[0]), .MISO(miso_w[0])
  );

  spi_master_tx #(.DIV(DIV1)) dut1 (
    .clk(clk), .clr(clr), .start(start_r[1]), .tx_data(txd_r[29:15]),
    .rx_data(rxd_w[29:15]), .busy(busy_w[1]), .done(done_w[1]),
    .SCLK(sclk_w[1]), .MOSI(mosi_w[1]), .LOAD(load_w[1]), .MISO(miso_w[1])
  );

  // Slave contract: a LOAD rise preloads TX from DI and latches the received
  // word to DO. The slave samples MOSI on the SCLK rise and shifts MISO on the
  // SCLK fall.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      ps_sclk[g] <= sclk_w[g];
      ps_load[g] <= load_w[g];
      if (load_w[g] && !ps_load[g]) begin
        s_do[g*15 +: 15] <= s_rx[g*15 +: 15];
        s_tx[g*15 +: 15] <= s_di[g*15 +: 15];
      end else begin
        if (sclk_w[g] && !ps_sclk[g])
          s_rx[g*15 +: 15] <= {s_rx[g*15 +: 14], mosi_w[g]};
        if (!sclk_w[g] && ps_sclk[g])
          s_tx[g*15 +: 15] <= {s_tx[g*15 +: 14], 1'b0};
      end
    end
  end

  assign miso_w = {s_tx[29], s_tx[14]};

  function automatic int div_of(input int u);
    return (u == 0) ? DIV0 : DIV1;
  endfunction

  // Runs one frame on instance u and checks its timing and data. With hold
  // set, start stays high so the next frame is accepted straight after done.
  // poke >= 0 pulses start with a different tx_data at that cycle of the frame.
  task automatic run_frame(input int u, input logic [14:0] tx, input logic [14:0] di,
                           input bit hold, input int poke, input string nm);
    int d, cyc, run, rises, loads, bad_run, bad_rise, toggles, busy_bad, done_cyc;
    logic prev_sclk, prev_load, prev_mosi, sclk, mosi, seen_done;
    logic [14:0] got_bits;
    d = div_of(u);
    cyc = -1; run = 0; rises = 0; loads = 0; bad_run = 0; bad_rise = 0;
    toggles = 0; busy_bad = 0; done_cyc = -1; seen_done = 1'b0; got_bits = '0;
    s_di[u*15 +: 15] = di;
    txd_r[u*15 +: 15] = tx;
    start_r[u] = 1'b1;
    prev_sclk = sclk_w[u]; prev_load = load_w[u]; prev_mosi = mosi_w[u];
    while (!seen_done && cyc < 40*d) begin
      @(negedge clk);
      cyc++;
      if (cyc == 0 && !hold) start_r[u] = 1'b0;
      if (cyc == poke) begin
        start_r[u] = 1'b1;
        txd_r[u*15 +: 15] = ~tx;
      end
      if (cyc == poke + 1 && !hold) start_r[u] = 1'b0;
      sclk = sclk_w[u];
      mosi = mosi_w[u];
      if (sclk !== prev_sclk) begin
        if (prev_sclk) begin
          if (run != d) bad_run++;
        end else if (rises == 0) begin
          if (run != 2*d) bad_run++;
        end else if (run != d) begin
          bad_run++;
        end
        run = 1;
        if (sclk) begin
          rises++;
          got_bits = {got_bits[13:0], mosi};
          if (cyc != 2*rises*d) bad_rise++;
        end
      end else begin
        run++;
      end
      if (sclk && prev_sclk && mosi !== prev_mosi) toggles++;
      if (load_w[u] && !prev_load) loads++;
      if (done_w[u] === 1'b1) begin
        seen_done = 1'b1;
        done_cyc = cyc;
      end else if (busy_w[u] !== 1'b1) begin
        busy_bad++;
      end
      prev_sclk = sclk; prev_load = load_w[u]; prev_mosi = mosi;
    end

    n_cmp++; if (done_cyc != 33*d) begin n_bad++;
      $display("FAIL %s latency: got %0d expected %0d", nm, done_cyc, 33*d); end
    n_cmp++; if (rxd_w[u*15 +: 15] !== di) begin n_bad++;
      $display("FAIL %s rx_data: got %h expected %h", nm, rxd_w[u*15 +: 15], di); end
    n_cmp++; if (s_do[u*15 +: 15] !== tx) begin n_bad++;
      $display("FAIL %s slave_do: got %h expected %h", nm, s_do[u*15 +: 15], tx); end
    n_cmp++; if (got_bits !== tx) begin n_bad++;
      $display("FAIL %s mosi_bits: got %h expected %h", nm, got_bits, tx); end
    n_cmp++; if (rises != 15) begin n_bad++;
      $display("FAIL %s sclk_rises: got %0d expected 15", nm, rises); end
    n_cmp++; if (loads != 2) begin n_bad++;
      $display("FAIL %s load_pulses: got %0d expected 2", nm, loads); end
    n_cmp++; if (bad_run != 0) begin n_bad++;
      $display("FAIL %s sclk_run_len: got %0d bad runs expected 0", nm, bad_run); end
    n_cmp++; if (bad_rise != 0) begin n_bad++;
      $display("FAIL %s sclk_rise_time: got %0d bad expected 0", nm, bad_rise); end
    n_cmp++; if (toggles != 0) begin n_bad++;
      $display("FAIL %s mosi_while_high: got %0d toggles expected 0", nm, toggles); end
    n_cmp++; if (busy_bad != 0) begin n_bad++;
      $display("FAIL %s busy_in_frame: got %0d low cycles expected 0", nm, busy_bad); end
    n_cmp++; if (busy_w[u] !== 1'b0) begin n_bad++;
      $display("FAIL %s busy_at_done: got %b expected 0", nm, busy_w[u]); end
    if (!hold) begin
      @(negedge clk);
      n_cmp++; if (done_w[u] !== 1'b0) begin n_bad++;
        $display("FAIL %s done_width: got %b expected 0", nm, done_w[u]); end
      n_cmp++; if (rxd_w[u*15 +: 15] !== di) begin n_bad++;
        $display("FAIL %s rx_hold: got %h expected %h", nm, rxd_w[u*15 +: 15], di); end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (rxd_w !== '0) begin n_bad++; $display("FAIL reset rx_data: got %h expected 0", rxd_w); end
    n_cmp++; if (busy_w !== '0) begin n_bad++; $display("FAIL reset busy: got %b expected 0", busy_w); end
    n_cmp++; if (done_w !== '0) begin n_bad++; $display("FAIL reset done: got %b expected 0", done_w); end
    n_cmp++; if (sclk_w !== '0) begin n_bad++; $display("FAIL reset sclk: got %b expected 0", sclk_w); end
    n_cmp++; if (mosi_w !== '0) begin n_bad++; $display("FAIL reset mosi: got %b expected 0", mosi_w); end
    n_cmp++; if (load_w !== '0) begin n_bad++; $display("FAIL reset load: got %b expected 0", load_w); end
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_loopback();
    run_frame(0, 15'h2B71, 15'h5A3C, 1'b0, -10, "loopback");
  endtask

  task automatic test_reset_midframe();
    int seen;
    s_di[14:0] = 15'(($urandom));
    txd_r[14:0] = 15'h1357;
    start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    // Sample index 61 lies in the LOW phase of bit 7 (cycles 60..63 at DIV=4).
    repeat (61) @(negedge clk);
    n_cmp++; if (busy_w[0] !== 1'b1 || sclk_w[0] !== 1'b0) begin n_bad++;
      $display("FAIL midreset pre_state: got busy=%b sclk=%b expected busy=1 sclk=0", busy_w[0], sclk_w[0]); end
    clr = 1'b1;
    @(negedge clk);
    n_cmp++; if (sclk_w[0] !== 1'b0) begin n_bad++; $display("FAIL midreset sclk: got %b expected 0", sclk_w[0]); end
    n_cmp++; if (load_w[0] !== 1'b0) begin n_bad++; $display("FAIL midreset load: got %b expected 0", load_w[0]); end
    n_cmp++; if (mosi_w[0] !== 1'b0) begin n_bad++; $display("FAIL midreset mosi: got %b expected 0", mosi_w[0]); end
    n_cmp++; if (busy_w[0] !== 1'b0) begin n_bad++; $display("FAIL midreset busy: got %b expected 0", busy_w[0]); end
    n_cmp++; if (rxd_w[14:0] !== 15'h0) begin n_bad++; $display("FAIL midreset rx_data: got %h expected 0", rxd_w[14:0]); end
    repeat (2) @(negedge clk);
    clr = 1'b0;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b0) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL midreset quiet: got %0d active cycles expected 0", seen); end
  endtask

  task automatic test_patterns();
    run_frame(0, 15'h0000, 15'h7FFF, 1'b0, -10, "pattern0");
    run_frame(0, 15'h7FFF, 15'h0000, 1'b0, -10, "pattern1");
    run_frame(0, 15'h5555, 15'h2AAA, 1'b0, -10, "pattern2");
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      run_frame(0, 15'($urandom), 15'($urandom), 1'b0, -10, "random_div4");
      run_frame(1, 15'($urandom), 15'($urandom), 1'b0, -10, "random_div2");
    end
  endtask

  task automatic test_back_to_back();
    int active;
    run_frame(0, 15'h6A5B, 15'h13C4, 1'b1, -10, "b2b_first");
    run_frame(0, 15'h0F0F, 15'h7531, 1'b1, -10, "b2b_second");
    start_r[0] = 1'b0;
    active = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy_w[0] !== 1'b0 || load_w[0] !== 1'b0) active++;
    end
    n_cmp++; if (active != 0) begin n_bad++; $display("FAIL b2b_stop: got %0d active cycles expected 0", active); end
  endtask

  task automatic test_busy_lockout();
    int active;
    run_frame(0, 15'h3C5A, 15'h4DB2, 1'b0, 50, "lockout");
    active = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (busy_w[0] !== 1'b0 || load_w[0] !== 1'b0) active++;
    end
    n_cmp++; if (active != 0) begin n_bad++; $display("FAIL lockout_extra_frame: got %0d active cycles expected 0", active); end
  endtask

  task automatic test_div2();
    run_frame(1, 15'h4001, 15'h1234, 1'b0, -10, "div2");
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_reset_midframe();
    test_patterns();
    test_random();
    test_back_to_back();
    test_busy_lockout();
    test_div2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
